// File: rtl/dma_descriptor_scheduler.sv
// Round-robin DMA descriptor scheduler: arbitrates NUM_CH requesters into a FIFO and dispatches one descriptor at a time.
// Latency: push at N -> pop at N+1 -> descp_avail at N+2; done_pulse two cycles after the processor is seen idle again.
// Backpressure: req_ready is withheld from every channel while the registered FIFO count is at FIFO_DEPTH.
module dma_descriptor_scheduler #(
    parameter int          NUM_CH     = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [2:0]  PROC_IDLE  = 3'b000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             req_valid,
    output logic [NUM_CH-1:0]             req_ready,
    input  logic [16*NUM_CH-1:0]          req_read_from,
    input  logic [18*NUM_CH-1:0]          req_write_to,
    input  logic [16*NUM_CH-1:0]          req_length,
    output logic                          descp_avail,
    output logic [15:0]                   read_from,
    output logic [17:0]                   write_to,
    output logic [15:0]                   length_data,
    input  logic [2:0]                    proc_state,
    output logic                          done_pulse,
    output logic [$clog2(NUM_CH)-1:0]     done_ch,
    output logic                          done_err,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(NUM_CH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [15:0]   rd;
        logic [17:0]   wr;
        logic [15:0]   len;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_START, S_WAIT_DONE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] rr_q, rr_d;
    logic [CW-1:0] grant_ch;
    logic          grant_vld;
    logic          push, pop;
    logic [NW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        push_ent, head;
    logic [15:0]   rd_q;
    logic [17:0]   wr_q;
    logic [15:0]   len_q;
    logic [CW-1:0] cur_ch_q;
    logic          err_q;
    logic          done_pulse_q, done_err_q;
    logic [CW-1:0] done_ch_q;

    // Search starts at the RR pointer and wraps; fullness uses the registered count only.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        if (count_q < NW'(FIFO_DEPTH)) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!grant_vld && req_valid[(int'(rr_q) + k) % NUM_CH]) begin
                    grant_vld = 1'b1;
                    grant_ch  = CW'((int'(rr_q) + k) % NUM_CH);
                end
            end
        end
        req_ready = grant_vld ? (NUM_CH'(1) << grant_ch) : '0;
        push      = grant_vld;
        rr_d      = rr_q;
        if (push) begin
            rr_d = (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + 1'b1;
        end
    end

    always_comb begin
        push_ent.ch  = grant_ch;
        push_ent.rd  = req_read_from[16*grant_ch +: 16];
        push_ent.wr  = req_write_to[18*grant_ch +: 18];
        push_ent.len = req_length[16*grant_ch +: 16];
        head         = mem_q[rd_ptr_q];
        count_d      = count_q + NW'(push) - NW'(pop);
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        descp_avail = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = (head.len == '0) ? S_DONE : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (proc_state == PROC_IDLE) begin
                    descp_avail = 1'b1;
                    state_d     = S_WAIT_START;
                end
            end
            S_WAIT_START: if (proc_state != PROC_IDLE) state_d = S_WAIT_DONE;
            S_WAIT_DONE:  if (proc_state == PROC_IDLE) state_d = S_DONE;
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            len_q        <= '0;
            cur_ch_q     <= '0;
            err_q        <= 1'b0;
            done_pulse_q <= 1'b0;
            done_err_q   <= 1'b0;
            done_ch_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rd_q     <= head.rd;
                wr_q     <= head.wr;
                len_q    <= head.len;
                cur_ch_q <= head.ch;
                err_q    <= (head.len == '0);
            end
            done_pulse_q <= (state_q == S_DONE);
            done_err_q   <= (state_q == S_DONE) && err_q;
            if (state_q == S_DONE) done_ch_q <= cur_ch_q;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_ent;
    end

    assign read_from   = rd_q;
    assign write_to    = wr_q;
    assign length_data = len_q;
    assign done_pulse  = done_pulse_q;
    assign done_ch     = done_ch_q;
    assign done_err    = done_err_q;
    assign fifo_count  = count_q;
    assign busy        = (count_q != '0) || (state_q != S_IDLE);

endmodule
